// File: rtl/a_b_req_arbiter.sv
// Round-robin arbiter that funnels NUM_REQ valid/ready requesters onto the
// single A->B request channel as registered one-cycle pulses with a minimum idle gap.
module a_b_req_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 12,
  parameter int MIN_GAP = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_address,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic                      b_stall,
  output logic                      Valid,
  output logic [ADDR_W-1:0]         Address,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                      busy
);

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int GAP_W = 4;

  logic              valid_q, valid_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ID_W-1:0]   gid_q, gid_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [GAP_W-1:0]  gap_q, gap_d;

  logic              can_accept;
  logic              hit;
  logic              hs;
  logic [ID_W-1:0]   win;

  // Wraps base+k into 0..NUM_REQ-1; also correct for non-power-of-two NUM_REQ.
  function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return ID_W'(s);
  endfunction

  always_comb begin
    can_accept = !rst && !b_stall && (gap_q == '0);
    hit        = 1'b0;
    win        = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!hit && req_valid[wrap_add(ptr_q, k)]) begin
        hit = 1'b1;
        win = wrap_add(ptr_q, k);
      end
    end
    hs        = can_accept && hit;
    req_ready = '0;
    if (hs) req_ready[win] = 1'b1;
  end

  always_comb begin
    valid_d = hs;
    addr_d  = addr_q;
    gid_d   = gid_q;
    ptr_d   = ptr_q;
    gap_d   = (gap_q != '0) ? gap_q - 1'b1 : '0;
    if (hs) begin
      addr_d = req_address[int'(win)*ADDR_W +: ADDR_W];
      gid_d  = win;
      ptr_d  = wrap_add(win, 1);
      gap_d  = GAP_W'(MIN_GAP);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      addr_q  <= '0;
      gid_q   <= '0;
      ptr_q   <= '0;
      gap_q   <= '0;
    end else begin
      valid_q <= valid_d;
      addr_q  <= addr_d;
      gid_q   <= gid_d;
      ptr_q   <= ptr_d;
      gap_q   <= gap_d;
    end
  end

  assign Valid    = valid_q;
  assign Address  = addr_q;
  assign grant_id = gid_q;
  assign busy     = valid_q || (gap_q != '0);

endmodule

// File: tb/tb_a_b_req_arbiter.sv
// Drives three arbiters (MIN_GAP 0/2/5) with directed then random traffic and
// compares every cycle against a transaction-level model of the grant rules.
module tb_a_b_req_arbiter;

  localparam int NR = 4;
  localparam int AW = 12;
  localparam int NI = 3;
  localparam int GAPS[NI] = '{0, 2, 5};

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic b_stall = 1'b0;
  logic [NR-1:0]    rv  [NI];
  logic [NR*AW-1:0] ra  [NI];
  logic [NR-1:0]    rdy [NI];
  logic             vld [NI];
  logic [AW-1:0]    addr[NI];
  logic [1:0]       gid [NI];
  logic             bsy [NI];

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < NI; gi++) begin : g_dut
    a_b_req_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .MIN_GAP(GAPS[gi])) u_dut (
      .clk         (clk),
      .rst         (rst),
      .req_valid   (rv[gi]),
      .req_address (ra[gi]),
      .req_ready   (rdy[gi]),
      .b_stall     (b_stall),
      .Valid       (vld[gi]),
      .Address     (addr[gi]),
      .grant_id    (gid[gi]),
      .busy        (bsy[gi])
    );
  end

  // reference state: next requester to favour, cycles left in the gap, last pulse
  int          m_ptr [NI];
  int          m_gap [NI];
  logic        m_vld [NI];
  logic [AW-1:0] m_addr[NI];
  int          m_gid [NI];
  bit          drop_hs;
  int          n_chk = 0;
  int          n_err = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic int model_win(input int k);
    if (rst || b_stall || m_gap[k] != 0) return -1;
    for (int s = 0; s < NR; s++) begin
      int i;
      i = (m_ptr[k] + s) % NR;
      if (rv[k][i]) return i;
    end
    return -1;
  endfunction

  task automatic tick();
    int w[NI];
    #1;
    for (int k = 0; k < NI; k++) begin
      w[k] = model_win(k);
      chk($sformatf("ready[%0d]", k), 32'(rdy[k]), (w[k] >= 0) ? (32'd1 << w[k]) : 32'd0);
    end
    @(posedge clk);
    for (int k = 0; k < NI; k++) begin
      if (rst) begin
        m_ptr[k] = 0; m_gap[k] = 0; m_vld[k] = 1'b0; m_addr[k] = '0; m_gid[k] = 0;
      end else if (w[k] >= 0) begin
        m_vld[k]  = 1'b1;
        m_addr[k] = ra[k][w[k]*AW +: AW];
        m_gid[k]  = w[k];
        m_ptr[k]  = (w[k] + 1) % NR;
        m_gap[k]  = GAPS[k];
      end else begin
        m_vld[k] = 1'b0;
        if (m_gap[k] > 0) m_gap[k]--;
      end
    end
    #1;
    for (int k = 0; k < NI; k++) begin
      chk($sformatf("valid[%0d]", k), 32'(vld[k]), 32'(m_vld[k]));
      chk($sformatf("addr[%0d]", k), 32'(addr[k]), 32'(m_addr[k]));
      chk($sformatf("gid[%0d]", k), 32'(gid[k]), 32'(m_gid[k]));
      chk($sformatf("busy[%0d]", k), 32'(bsy[k]), 32'(m_vld[k] || m_gap[k] != 0));
      if (drop_hs && !rst && w[k] >= 0) rv[k][w[k]] = 1'b0;
    end
  endtask

  task automatic set_all(input logic [NR-1:0] v);
    for (int k = 0; k < NI; k++) rv[k] = v;
  endtask

  task automatic set_addr(input int i, input logic [AW-1:0] a);
    for (int k = 0; k < NI; k++) ra[k][i*AW +: AW] = a;
  endtask

  initial begin
    for (int k = 0; k < NI; k++) begin
      rv[k] = '0; ra[k] = '0;
      m_ptr[k] = 0; m_gap[k] = 0; m_vld[k] = 1'b0; m_addr[k] = '0; m_gid[k] = 0;
    end
    drop_hs = 1'b1;
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    tick();

    // single requester, then pointer wrap from rr_ptr=3 with 0 and 3 pending
    set_addr(2, 12'h3A5);
    set_all(4'b0100);
    repeat (3) tick();
    set_addr(0, 12'h0AA);
    set_addr(3, 12'h3CC);
    set_all(4'b1001);
    repeat (14) tick();

    // continuous round robin on all four
    drop_hs = 1'b0;
    for (int i = 0; i < NR; i++) set_addr(i, 12'(i * 'h111));
    set_all(4'b1111);
    repeat (16) tick();

    // two requesters always valid: exercises gap pattern
    set_all(4'b0011);
    repeat (14) tick();

    // stall while requester 3 waits
    set_all(4'b0000);
    repeat (6) tick();
    drop_hs = 1'b1;
    set_addr(3, 12'h5E3);
    set_all(4'b1000);
    b_stall = 1'b1;
    repeat (3) tick();
    b_stall = 1'b0;
    repeat (3) tick();

    // reset one cycle after a handshake, then immediate restart from requester 0
    set_all(4'b0110);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    set_all(4'b0011);
    repeat (4) tick();

    // random traffic with stalls and occasional resets
    for (int c = 0; c < 600; c++) begin
      for (int k = 0; k < NI; k++)
        for (int i = 0; i < NR; i++)
          if (!rv[k][i] && $urandom_range(2) == 0) begin
            rv[k][i] = 1'b1;
            ra[k][i*AW +: AW] = AW'($urandom);
          end
      b_stall = ($urandom_range(4) == 0);
      rst     = ($urandom_range(59) == 0);
      tick();
    end
    rst = 1'b0;
    b_stall = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
